// File: rtl/al_commit_reader.sv
// Active-list commit reader: retires up to two completed entries per cycle in order
// and tracks allocation at the tail. Define AL_COMMIT_PERF_EN to add a commit counter.
module al_commit_reader #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic [2:0]         alloc_cnt_i,
  input  logic [DEPTH-1:0]   done_vec_i,
  input  logic               stall_i,
  output logic [INDEX-1:0]   rd_addr0_o,
  output logic [INDEX-1:0]   rd_addr1_o,
  input  logic [WIDTH-1:0]   rd_data0_i,
  input  logic [WIDTH-1:0]   rd_data1_i,
  output logic               commit_valid0_o,
  output logic               commit_valid1_o,
  output logic [WIDTH-1:0]   commit_data0_o,
  output logic [WIDTH-1:0]   commit_data1_o,
  output logic [INDEX:0]     free_cnt_o,
`ifdef AL_COMMIT_PERF_EN
  output logic [15:0]        perf_commit_cnt_o,
`endif
  output logic               ovf_err_o
);

  localparam logic [INDEX:0] DepthVal = (INDEX+1)'(DEPTH);

  logic [INDEX-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [INDEX:0]   count_q, count_d, alloc_ext, alloc_acc, commit_ext;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             ovf_q, ovf_d;
  logic             elig0, elig1, alloc_ok;
  logic [1:0]       commit_num;

  assign head_nxt   = head_q + 1'b1;
  assign rd_addr0_o = head_q;
  assign rd_addr1_o = head_nxt;
  assign free_cnt_o = DepthVal - count_q;

  // Retirement is strictly in order: slot 1 only goes when slot 0 does.
  assign elig0      = (count_q != '0) && done_vec_i[head_q] && !stall_i;
  assign elig1      = elig0 && (count_q >= (INDEX+1)'(2)) && done_vec_i[head_nxt];
  assign commit_num = {1'b0, elig0} + {1'b0, elig1};
  assign commit_ext = (INDEX+1)'(commit_num);

  // Allocation is judged against the pre-commit free count; oversize requests drop whole.
  assign alloc_ext  = (INDEX+1)'(alloc_cnt_i);
  assign alloc_ok   = (alloc_ext <= free_cnt_o);
  assign alloc_acc  = alloc_ok ? alloc_ext : '0;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    data0_d  = data0_q;
    data1_d  = data1_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d   = head_q + INDEX'(commit_num);
      tail_d   = tail_q + alloc_acc[INDEX-1:0];
      count_d  = count_q + alloc_acc - commit_ext;
      valid0_d = elig0;
      valid1_d = elig1;
      if (elig0) data0_d = rd_data0_i;
      if (elig1) data1_d = rd_data1_i;
      if (!alloc_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      ovf_q    <= ovf_d;
    end
  end

  assign commit_valid0_o = valid0_q;
  assign commit_valid1_o = valid1_q;
  assign commit_data0_o  = data0_q;
  assign commit_data1_o  = data1_q;
  assign ovf_err_o       = ovf_q;

`ifdef AL_COMMIT_PERF_EN
  logic [15:0] perf_q, perf_d;
  logic [16:0] perf_sum;

  // Counts only commits that actually happen, so a flush contributes nothing.
  always_comb begin
    perf_sum = {1'b0, perf_q} + (flush_i ? 17'd0 : 17'(commit_num));
    perf_d   = perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_commit_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_al_commit_reader.sv
// Directed bench for al_commit_reader: allocation, in-order dual commit, wrap,
// overflow, flush and reset behaviour, plus the perf counter when AL_COMMIT_PERF_EN is set.
module tb_al_commit_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [2:0]  alloc_cnt_i;
  logic [15:0] done_vec_i;
  logic        stall_i;
  logic [3:0]  rd_addr0_o, rd_addr1_o;
  logic [7:0]  rd_data0_i, rd_data1_i;
  logic        commit_valid0_o, commit_valid1_o;
  logic [7:0]  commit_data0_o, commit_data1_o;
  logic [4:0]  free_cnt_o;
  logic        ovf_err_o;
`ifdef AL_COMMIT_PERF_EN
  logic [15:0] perf_commit_cnt_o;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  // Payload RAM: entry i holds 0xA0 + i.
  assign rd_data0_i = 8'hA0 + 8'(rd_addr0_o);
  assign rd_data1_i = 8'hA0 + 8'(rd_addr1_o);

  al_commit_reader dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .alloc_cnt_i     (alloc_cnt_i),
    .done_vec_i      (done_vec_i),
    .stall_i         (stall_i),
    .rd_addr0_o      (rd_addr0_o),
    .rd_addr1_o      (rd_addr1_o),
    .rd_data0_i      (rd_data0_i),
    .rd_data1_i      (rd_data1_i),
    .commit_valid0_o (commit_valid0_o),
    .commit_valid1_o (commit_valid1_o),
    .commit_data0_o  (commit_data0_o),
    .commit_data1_o  (commit_data1_o),
    .free_cnt_o      (free_cnt_o),
`ifdef AL_COMMIT_PERF_EN
    .perf_commit_cnt_o (perf_commit_cnt_o),
`endif
    .ovf_err_o       (ovf_err_o)
  );

  // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic fl, input logic [2:0] al, input logic [15:0] dn, input logic st);
    flush_i     = fl;
    alloc_cnt_i = al;
    done_vec_i  = dn;
    stall_i     = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
    reset = 1'b0;
    checkCount++; if (free_cnt_o !== 5'd16) begin errorCount++; $display("[TB] FAIL reset_free: got %0d expected 16", free_cnt_o); end
    checkCount++; if ({commit_valid0_o, commit_valid1_o, ovf_err_o} !== 3'b000) begin errorCount++; $display("[TB] FAIL reset_flags: got %b expected 000", {commit_valid0_o, commit_valid1_o, ovf_err_o}); end
    checkCount++; if ({commit_data0_o, commit_data1_o} !== 16'h0000) begin errorCount++; $display("[TB] FAIL reset_data: got %h expected 0000", {commit_data0_o, commit_data1_o}); end
    checkCount++; if ({rd_addr0_o, rd_addr1_o} !== 8'h01) begin errorCount++; $display("[TB] FAIL reset_addr: got %h expected 01", {rd_addr0_o, rd_addr1_o}); end
  endtask

  task automatic test_alloc();
    applyStimulus(1'b0, 3'd3, 16'h0000, 1'b0);
    checkCount++; if (free_cnt_o !== 5'd13) begin errorCount++; $display("[TB] FAIL alloc_free: got %0d expected 13", free_cnt_o); end
    checkCount++; if ({commit_valid0_o, commit_valid1_o} !== 2'b00) begin errorCount++; $display("[TB] FAIL alloc_valids: got %b expected 00", {commit_valid0_o, commit_valid1_o}); end
  endtask

  task automatic test_in_order();
    applyStimulus(1'b0, 3'd0, 16'h0002, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o} !== 2'b00) begin errorCount++; $display("[TB] FAIL inorder_block: got %b expected 00", {commit_valid0_o, commit_valid1_o}); end
    checkCount++; if (free_cnt_o !== 5'd13) begin errorCount++; $display("[TB] FAIL inorder_block_free: got %0d expected 13", free_cnt_o); end
    applyStimulus(1'b0, 3'd0, 16'h0003, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o} !== 2'b11) begin errorCount++; $display("[TB] FAIL inorder_dual: got %b expected 11", {commit_valid0_o, commit_valid1_o}); end
    checkCount++; if ({commit_data0_o, commit_data1_o} !== 16'hA0A1) begin errorCount++; $display("[TB] FAIL inorder_data: got %h expected a0a1", {commit_data0_o, commit_data1_o}); end
    checkCount++; if ({free_cnt_o, rd_addr0_o} !== {5'd15, 4'd2}) begin errorCount++; $display("[TB] FAIL inorder_state: got free %0d head %0d expected 15 2", free_cnt_o, rd_addr0_o); end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o, commit_data0_o, commit_data1_o} !== {2'b00, 16'hA0A1}) begin errorCount++; $display("[TB] FAIL hold_data: got %b %h expected 00 a0a1", {commit_valid0_o, commit_valid1_o}, {commit_data0_o, commit_data1_o}); end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd3, 16'h0000, 1'b0);
    checkCount++; if (free_cnt_o !== 5'd0) begin errorCount++; $display("[TB] FAIL fill_free: got %0d expected 0", free_cnt_o); end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'd0, 16'hFFFF, 1'b0);
    checkCount++; if ({free_cnt_o, rd_addr0_o, rd_addr1_o} !== {5'd12, 4'd14, 4'd15}) begin errorCount++; $display("[TB] FAIL pre_wrap: got free %0d addr %0d/%0d expected 12 14/15", free_cnt_o, rd_addr0_o, rd_addr1_o); end
    applyStimulus(1'b0, 3'd0, 16'hFFFF, 1'b1);
    checkCount++; if ({commit_valid0_o, commit_valid1_o, rd_addr0_o} !== {2'b00, 4'd14}) begin errorCount++; $display("[TB] FAIL stall: got %b head %0d expected 00 14", {commit_valid0_o, commit_valid1_o}, rd_addr0_o); end
    applyStimulus(1'b0, 3'd0, 16'hC000, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o, commit_data0_o, commit_data1_o} !== {2'b11, 16'hAEAF}) begin errorCount++; $display("[TB] FAIL wrap_commit: got %b %h expected 11 aeaf", {commit_valid0_o, commit_valid1_o}, {commit_data0_o, commit_data1_o}); end
    checkCount++; if ({free_cnt_o, rd_addr0_o} !== {5'd14, 4'd0}) begin errorCount++; $display("[TB] FAIL wrap_state: got free %0d head %0d expected 14 0", free_cnt_o, rd_addr0_o); end
  endtask

  task automatic test_overflow();
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd1, 16'h0000, 1'b0);
    checkCount++; if ({free_cnt_o, ovf_err_o} !== {5'd1, 1'b0}) begin errorCount++; $display("[TB] FAIL pre_ovf: got free %0d ovf %b expected 1 0", free_cnt_o, ovf_err_o); end
    applyStimulus(1'b0, 3'd2, 16'h0001, 1'b0);
    checkCount++; if (ovf_err_o !== 1'b1) begin errorCount++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf_err_o); end
    checkCount++; if ({free_cnt_o, rd_addr0_o} !== {5'd2, 4'd1}) begin errorCount++; $display("[TB] FAIL ovf_state: got free %0d head %0d expected 2 1", free_cnt_o, rd_addr0_o); end
    checkCount++; if ({commit_valid0_o, commit_valid1_o, commit_data0_o, commit_data1_o} !== {2'b10, 16'hA0AF}) begin errorCount++; $display("[TB] FAIL ovf_commit: got %b %h expected 10 a0af", {commit_valid0_o, commit_valid1_o}, {commit_data0_o, commit_data1_o}); end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
    checkCount++; if ({ovf_err_o, commit_valid0_o} !== 2'b10) begin errorCount++; $display("[TB] FAIL ovf_sticky: got %b expected 10", {ovf_err_o, commit_valid0_o}); end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 3'd2, 16'hFFFF, 1'b0);
    checkCount++; if ({free_cnt_o, rd_addr0_o} !== {5'd16, 4'd15}) begin errorCount++; $display("[TB] FAIL flush_state: got free %0d head %0d expected 16 15", free_cnt_o, rd_addr0_o); end
    checkCount++; if ({commit_valid0_o, commit_valid1_o, ovf_err_o} !== 3'b001) begin errorCount++; $display("[TB] FAIL flush_flags: got %b expected 001", {commit_valid0_o, commit_valid1_o, ovf_err_o}); end
    applyStimulus(1'b0, 3'd2, 16'h0000, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'hFFFF, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o, commit_data0_o, commit_data1_o} !== {2'b11, 16'hAFA0}) begin errorCount++; $display("[TB] FAIL flush_tail: got %b %h expected 11 afa0", {commit_valid0_o, commit_valid1_o}, {commit_data0_o, commit_data1_o}); end
    checkCount++; if ({free_cnt_o, rd_addr0_o} !== {5'd16, 4'd1}) begin errorCount++; $display("[TB] FAIL post_flush: got free %0d head %0d expected 16 1", free_cnt_o, rd_addr0_o); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd4, 16'h0000, 1'b0);
    checkCount++; if (free_cnt_o !== 5'd0) begin errorCount++; $display("[TB] FAIL alloc_exact: got %0d expected 0", free_cnt_o); end
  endtask

  task automatic test_reset_mid_commit();
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'hFFFF, 1'b0);
    reset = 1'b0;
    checkCount++; if ({commit_valid0_o, commit_valid1_o, ovf_err_o, commit_data0_o, commit_data1_o} !== 19'd0) begin errorCount++; $display("[TB] FAIL midreset_out: got %b %h expected 000 0000", {commit_valid0_o, commit_valid1_o, ovf_err_o}, {commit_data0_o, commit_data1_o}); end
    checkCount++; if (free_cnt_o !== 5'd16) begin errorCount++; $display("[TB] FAIL midreset_free: got %0d expected 16", free_cnt_o); end
    applyStimulus(1'b0, 3'd0, 16'hFFFF, 1'b0);
    checkCount++; if ({commit_valid0_o, commit_valid1_o} !== 2'b00) begin errorCount++; $display("[TB] FAIL midreset_after: got %b expected 00", {commit_valid0_o, commit_valid1_o}); end
  endtask

`ifdef AL_COMMIT_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
    reset = 1'b0;
    checkCount++; if (perf_commit_cnt_o !== 16'd0) begin errorCount++; $display("[TB] FAIL perf_reset: got %0d expected 0", perf_commit_cnt_o); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd2, 16'hFFFF, 1'b0);
    checkCount++; if (perf_commit_cnt_o !== 16'd6) begin errorCount++; $display("[TB] FAIL perf_count: got %0d expected 6", perf_commit_cnt_o); end
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b0);
    checkCount++; if (perf_commit_cnt_o !== 16'd6) begin errorCount++; $display("[TB] FAIL perf_flush: got %0d expected 6", perf_commit_cnt_o); end
    for (int i = 0; i < 40001; i++) applyStimulus(1'b0, 3'd2, 16'hFFFF, 1'b0);
    checkCount++; if (perf_commit_cnt_o !== 16'hFFFF) begin errorCount++; $display("[TB] FAIL perf_sat: got %h expected ffff", perf_commit_cnt_o); end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    flush_i     = 1'b0;
    alloc_cnt_i = 3'd0;
    done_vec_i  = 16'h0000;
    stall_i     = 1'b0;
    @(negedge clk);
    test_reset();
    test_alloc();
    test_in_order();
    test_wrap();
    test_overflow();
    test_flush();
    test_reset_mid_commit();
`ifdef AL_COMMIT_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
